// File: rtl/rv_pkg.sv
// Shared types and constants for the RISC-V writeback stage.
package rv_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_NONE = 2'd3
    } res_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE    = 2'd0;
    localparam wb_state_t ST_WB      = 2'd1;
    localparam wb_state_t ST_WAIT_LD = 2'd2;

endpackage

// File: rtl/rv_load_align.sv
// Load data alignment and sign/zero extension, plus misalignment detection.
module rv_load_align
    import rv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    // Unlisted funct3 encodings fall through to word behaviour.
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h000000, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {16'h0000, half_sel};
                misaligned = off[0];
            end
            default: misaligned = (off != 2'b00);
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage: selects the result, waits for load data, drives the register-file write port.
module rv_writeback
    import rv_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [4:0]           i_rd,
    input  logic [1:0]           i_res_src,
    input  logic [31:0]          i_alu_result,
    input  logic [31:0]          i_pc4,
    input  logic [2:0]           i_funct3,
    input  logic                 i_dmem_rvalid,
    input  logic [31:0]          i_dmem_rdata,
    output logic [4:0]           o_rd,
    output logic                 o_write,
    output logic [31:0]          o_data,
    output logic                 o_ld_pending,
    output logic [4:0]           o_ld_rd,
    output logic                 o_misaligned,
    output logic                 o_retire,
    output logic [INSTRET_W-1:0] o_instret
);

    wb_state_t            state, state_nxt;
    logic [1:0]           ld_off, ld_off_nxt;
    logic [2:0]           ld_f3, ld_f3_nxt;
    logic [4:0]           rd_nxt, ld_rd_nxt;
    logic [31:0]          data_nxt;
    logic                 write_nxt, retire_nxt, mis_nxt, ld_pending_nxt;
    logic [INSTRET_W-1:0] instret_nxt;

    logic                 accept;
    logic [1:0]           al_off;
    logic [2:0]           al_f3;
    logic [31:0]          al_data;
    logic                 al_mis;

    assign o_ready = (state != ST_WAIT_LD) && !i_reset;
    assign accept  = i_valid && (state != ST_WAIT_LD);

    // While waiting, align with the captured offset/size; otherwise check the incoming load.
    assign al_off = (state == ST_WAIT_LD) ? ld_off : i_alu_result[1:0];
    assign al_f3  = (state == ST_WAIT_LD) ? ld_f3  : i_funct3;

    rv_load_align u_align (
        .word       (i_dmem_rdata),
        .off        (al_off),
        .funct3     (al_f3),
        .data       (al_data),
        .misaligned (al_mis)
    );

    always_comb begin
        state_nxt      = state;
        rd_nxt         = o_rd;
        data_nxt       = o_data;
        write_nxt      = 1'b0;
        retire_nxt     = 1'b0;
        mis_nxt        = 1'b0;
        ld_pending_nxt = o_ld_pending;
        ld_rd_nxt      = o_ld_rd;
        ld_off_nxt     = ld_off;
        ld_f3_nxt      = ld_f3;
        instret_nxt    = o_instret;

        case (state)
            ST_WAIT_LD: begin
                if (i_dmem_rvalid) begin
                    state_nxt      = ST_WB;
                    ld_pending_nxt = 1'b0;
                    retire_nxt     = 1'b1;
                    instret_nxt    = o_instret + INSTRET_W'(1);
                    if (o_ld_rd != 5'd0) begin
                        write_nxt = 1'b1;
                        rd_nxt    = o_ld_rd;
                        data_nxt  = al_data;
                    end
                end
            end
            default: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (i_res_src == RES_LOAD) begin
                    if (al_mis) begin
                        state_nxt = ST_WB;
                        mis_nxt   = 1'b1;
                    end else begin
                        state_nxt      = ST_WAIT_LD;
                        ld_pending_nxt = 1'b1;
                        ld_rd_nxt      = i_rd;
                        ld_off_nxt     = i_alu_result[1:0];
                        ld_f3_nxt      = i_funct3;
                    end
                end else begin
                    state_nxt   = ST_WB;
                    retire_nxt  = 1'b1;
                    instret_nxt = o_instret + INSTRET_W'(1);
                    if ((i_res_src != RES_NONE) && (i_rd != 5'd0)) begin
                        write_nxt = 1'b1;
                        rd_nxt    = i_rd;
                        data_nxt  = (i_res_src == RES_PC4) ? i_pc4 : i_alu_result;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_rd         <= '0;
            o_data       <= '0;
            o_write      <= 1'b0;
            o_retire     <= 1'b0;
            o_misaligned <= 1'b0;
            o_ld_pending <= 1'b0;
            o_ld_rd      <= '0;
            ld_off       <= '0;
            ld_f3        <= '0;
            o_instret    <= '0;
        end else begin
            state        <= state_nxt;
            o_rd         <= rd_nxt;
            o_data       <= data_nxt;
            o_write      <= write_nxt;
            o_retire     <= retire_nxt;
            o_misaligned <= mis_nxt;
            o_ld_pending <= ld_pending_nxt;
            o_ld_rd      <= ld_rd_nxt;
            ld_off       <= ld_off_nxt;
            ld_f3        <= ld_f3_nxt;
            o_instret    <= instret_nxt;
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// Scoreboard bench for rv_writeback: stimulus pushes expected retire events, a monitor checks them.
module tb_rv_writeback;
    import rv_pkg::*;

    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [4:0]    rd_in;
    logic [1:0]    src;
    logic [31:0]   alu;
    logic [31:0]   pc4;
    logic [2:0]    f3;
    logic          rvalid;
    logic [31:0]   rdata;
    logic [4:0]    rd_out;
    logic          write;
    logic [31:0]   data;
    logic          ld_pending;
    logic [4:0]    ld_rd;
    logic          mis;
    logic          retire;
    logic [IW-1:0] instret;

    rv_writeback #(.INSTRET_W(IW)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
        .i_rd(rd_in), .i_res_src(src), .i_alu_result(alu), .i_pc4(pc4),
        .i_funct3(f3), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_rd(rd_out), .o_write(write), .o_data(data),
        .o_ld_pending(ld_pending), .o_ld_rd(ld_rd), .o_misaligned(mis),
        .o_retire(retire), .o_instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          mis;
        logic          retire;
        logic [IW-1:0] instret;
    } exp_t;

    exp_t          q[$];
    logic [IW-1:0] exp_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic push_ret(input logic w, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        exp_cnt   = exp_cnt + IW'(1);
        e.write   = w;
        e.rd      = r;
        e.data    = d;
        e.mis     = 1'b0;
        e.retire  = 1'b1;
        e.instret = exp_cnt;
        q.push_back(e);
    endtask

    task automatic push_mis();
        exp_t e;
        e.write   = 1'b0;
        e.rd      = '0;
        e.data    = '0;
        e.mis     = 1'b1;
        e.retire  = 1'b0;
        e.instret = exp_cnt;
        q.push_back(e);
    endtask

    // Monitor: every retire/misalign/write event must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (retire || mis || write)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {61'd0, write, retire, mis}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_flags", {61'd0, write, retire, mis}, {61'd0, e.write, e.retire, e.mis});
                if (e.write) begin
                    chk("wb_rd", 64'(rd_out), 64'(e.rd));
                    chk("wb_data", 64'(data), 64'(e.data));
                end
                if (e.retire) chk("instret", 64'(instret), 64'(e.instret));
            end
        end
    end

    task automatic issue(input logic [4:0] r, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] p, input logic [2:0] f);
        int n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
        valid = 1'b1; rd_in = r; src = s; alu = a; pc4 = p; f3 = f;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] w, input int delay, input logic [4:0] r);
        for (int i = 0; i < delay; i++) begin
            chk("wait_ready_low", 64'(ready), 64'd0);
            chk("wait_ld_pending", 64'(ld_pending), 64'd1);
            chk("wait_ld_rd", 64'(ld_rd), 64'(r));
            @(posedge clk); #1;
        end
        rvalid = 1'b1; rdata = w;
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rd_in = '0; src = '0; alu = '0; pc4 = '0; f3 = '0;
        rvalid = 1'b0; rdata = '0; exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_rd", 64'(rd_out), 64'd0);
        chk("rst_instret", 64'(instret), 64'd0);
        chk("rst_ld_pending", 64'(ld_pending), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready), 64'd1);

        // 1: ALU ADD
        push_ret(1'b1, 5'd5, 32'h1234_5678);
        issue(5'd5, RES_ALU, 32'h1234_5678, 32'h0, 3'b000);
        drain();

        // 2: LB offset 3, response after 3 waiting cycles
        issue(5'd7, RES_LOAD, 32'h0000_1003, 32'h0, F3_LB);
        push_ret(1'b1, 5'd7, 32'hFFFF_FF80);
        respond(32'h8000_0000, 3, 5'd7);
        chk("ld_pending_clear", 64'(ld_pending), 64'd0);
        drain();

        // 3: halfword/byte loads and misaligned cases
        issue(5'd8, RES_LOAD, 32'h0000_2002, 32'h0, F3_LHU);
        push_ret(1'b1, 5'd8, 32'h0000_BEEF);
        respond(32'hBEEF_0000, 1, 5'd8);
        drain();
        issue(5'd9, RES_LOAD, 32'h0000_2002, 32'h0, F3_LH);
        push_ret(1'b1, 5'd9, 32'hFFFF_8001);
        respond(32'h8001_0000, 2, 5'd9);
        drain();
        issue(5'd10, RES_LOAD, 32'h0000_0001, 32'h0, F3_LBU);
        push_ret(1'b1, 5'd10, 32'h0000_00A5);
        respond(32'h0000_A500, 1, 5'd10);
        drain();
        push_mis();
        issue(5'd11, RES_LOAD, 32'h0000_2001, 32'h0, F3_LH);
        chk("mis_no_wait_ready", 64'(ready), 64'd1);
        chk("mis_no_pending", 64'(ld_pending), 64'd0);
        drain();
        push_mis();
        issue(5'd12, RES_LOAD, 32'h0000_0002, 32'h0, F3_LW);
        drain();
        push_ret(1'b0, 5'd13, 32'h0);
        issue(5'd13, RES_NONE, 32'h5555_5555, 32'h0, 3'b000);
        drain();

        // 4: three back-to-back ALU ops
        do_reset();
        push_ret(1'b1, 5'd1, 32'h0000_0011);
        push_ret(1'b1, 5'd2, 32'h0000_0022);
        push_ret(1'b0, 5'd0, 32'h0);
        issue(5'd1, RES_ALU, 32'h0000_0011, 32'h0, 3'b000);
        issue(5'd2, RES_ALU, 32'h0000_0022, 32'h0, 3'b000);
        issue(5'd0, RES_ALU, 32'h0000_0033, 32'h0, 3'b000);
        chk("b2b_rate", 64'(q.size()), 64'd1);
        drain();
        chk("b2b_instret", 64'(instret), 64'd3);

        // 5: reset while waiting for a load, then a stray response
        issue(5'd9, RES_LOAD, 32'h0000_0000, 32'h0, F3_LW);
        #2;
        rst = 1'b1;
        q.delete();
        exp_cnt = '0;
        #1;
        chk("midrst_ld_pending", 64'(ld_pending), 64'd0);
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_instret", 64'(instret), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_no_write", 64'(write), 64'd0);
        chk("stray_no_pending", 64'(ld_pending), 64'd0);
        chk("stray_instret", 64'(instret), 64'd0);

        // 6: JAL result then counter wrap
        do_reset();
        push_ret(1'b1, 5'd1, 32'h0000_0100);
        issue(5'd1, RES_PC4, 32'hDEAD_BEEF, 32'h0000_0100, 3'b000);
        for (int i = 0; i < 16; i++) begin
            push_ret(1'b1, 5'd3, 32'(i));
            issue(5'd3, RES_ALU, 32'(i), 32'h0, 3'b000);
        end
        drain();
        chk("wrap_instret", 64'(instret), 64'd1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
